// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for a registered-read async FIFO: pops on !rempty, captures the
// 1-cycle-late rdata into a 2-entry buffer and presents a valid/ready stream with m_last framing.
module async_fifo_rd_stream #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);

  logic [1:0]       occ_reg, occ_next;
  logic             inflight_reg;
  logic [DSIZE-1:0] head_reg, head_next;
  logic [DSIZE-1:0] tail_reg, tail_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             fire;
  logic [2:0]       pending;
  logic [1:0]       occ_after_fire;

  assign m_valid = (occ_reg != 2'd0);
  assign fire    = m_valid & m_ready;
  assign m_data  = head_reg;
  assign m_last  = (cnt_reg == CNT_LAST) & m_valid;

  // Words already owned by this block (buffered or in flight) after this cycle's fire.
  assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, fire};
  assign rinc    = ~rrst & ~rempty & (pending < 3'd2);

  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    occ_after_fire = occ_reg - {1'b0, fire};
    cnt_next       = cnt_reg;
    occ_next       = pending[1:0];

    if (fire && occ_reg == 2'd2) begin
      head_next = tail_reg;
    end
    // Arriving word lands in the first free slot once this cycle's fire is accounted for.
    if (inflight_reg) begin
      if (occ_after_fire == 2'd0) begin
        head_next = rdata;
      end else begin
        tail_next = rdata;
      end
    end

    if (fire) begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      cnt_reg      <= '0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= rinc;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench: a queue-style FIFO model feeds three adapters (PKT_LEN 16/1/3); outputs are
// checked every cycle against word/pop/beat counts derived from the stream rules.
module tb_async_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       fifo_rst;
  logic       rempty;
  logic [7:0] rdata;
  logic       m_ready;

  logic       rinc16, rinc1, rinc3;
  logic       v16, v1, v3;
  logic       last16, last1, last3;
  logic [7:0] d16, d1, d3;

  always #5 rclk = ~rclk;

  async_fifo_rd_stream #(.DSIZE(8), .PKT_LEN(16)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc16), .rdata(rdata), .rempty(rempty),
    .m_valid(v16), .m_ready(m_ready), .m_data(d16), .m_last(last16)
  );
  async_fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1)) dut_p1 (
    .rclk(rclk), .rrst(rrst), .rinc(rinc1), .rdata(rdata), .rempty(rempty),
    .m_valid(v1), .m_ready(m_ready), .m_data(d1), .m_last(last1)
  );
  async_fifo_rd_stream #(.DSIZE(8), .PKT_LEN(3)) dut_p3 (
    .rclk(rclk), .rrst(rrst), .rinc(rinc3), .rdata(rdata), .rempty(rempty),
    .m_valid(v3), .m_ready(m_ready), .m_data(d3), .m_last(last3)
  );

  // FIFO model: write log plus read pointer; registered rempty and registered read data.
  logic [7:0] mem [0:4095];
  int wr_cnt = 0;
  int rd_ptr;

  always @(posedge rclk or posedge fifo_rst) begin
    if (fifo_rst) begin
      rd_ptr <= 0;
      rempty <= 1'b1;
      rdata  <= '0;
    end else if (rinc16 && !rempty) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      rempty <= (rd_ptr + 1 >= wr_cnt);
    end else begin
      rdata  <= 8'($urandom);
      rempty <= (rd_ptr >= wr_cnt);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n_pop words requested, n_cap of them captured, n_fire delivered.
  int  n_pop, n_cap, n_fire;
  int  dut_pops, dut_fires, vrise, cyc, first_cyc, last_cyc;
  int  lq16[$];
  int  lq3[$];
  int  lq1_cnt;
  bit  exp_valid, exp_fire, exp_rinc, prev_v;

  initial begin
    cyc = 0;
    forever begin
      @(negedge rclk);
      cyc++;
      if (rrst) begin
        n_pop = 0; n_cap = 0; n_fire = 0;
        dut_pops = 0; dut_fires = 0; vrise = 0; lq1_cnt = 0; prev_v = 0;
        lq16.delete();
        lq3.delete();
        check("rst_rinc", rinc16, 0);
        check("rst_valid", v16, 0);
        check("rst_last", last16, 0);
        check("rst_data", d16, 0);
      end else begin
        exp_valid = (n_cap > n_fire);
        exp_fire  = exp_valid && m_ready;
        exp_rinc  = !rempty && ((n_pop - n_fire - int'(exp_fire)) < 2);
        check("rinc", rinc16, exp_rinc);
        check("rinc_p1", rinc1, exp_rinc);
        check("rinc_p3", rinc3, exp_rinc);
        check("rinc_while_empty", rinc16 & rempty, 0);
        check("valid", v16, exp_valid);
        check("valid_p3", v3, exp_valid);
        if (exp_valid) begin
          check("data", d16, mem[n_fire]);
          check("data_p1", d1, mem[n_fire]);
        end
        check("last16", last16, exp_valid && (n_fire % 16 == 15));
        check("last1", last1, exp_valid);
        check("last3", last3, exp_valid && (n_fire % 3 == 2));

        if (v16 && m_ready) begin
          if (last16) lq16.push_back(dut_fires);
          if (last3) lq3.push_back(dut_fires);
          if (last1) lq1_cnt++;
          dut_fires++;
        end
        if (rinc16) dut_pops++;
        check("occ_le_2", (dut_pops - dut_fires) <= 2, 1);
        if (v16 && !prev_v) vrise++;
        prev_v = v16;
        if (exp_fire) begin
          if (n_fire == 0) first_cyc = cyc;
          last_cyc = cyc;
        end

        @(posedge rclk);
        if (!rrst) begin
          n_cap  = n_pop;
          n_pop  = n_pop + int'(exp_rinc);
          n_fire = n_fire + int'(exp_fire);
        end
      end
    end
  end

  task automatic write_word(input logic [7:0] d);
    mem[wr_cnt] = d;
    wr_cnt++;
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #1;
    rrst = 1'b1; fifo_rst = 1'b1; wr_cnt = 0;
    repeat (2) @(posedge rclk);
    #1;
    fifo_rst = 1'b0; rrst = 1'b0;
  endtask

  task automatic random_until(input int n, input int budget, input string name);
    for (int k = 0; k < budget && n_fire < n; k++) begin
      @(posedge rclk);
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
    check(name, n_fire, n);
  endtask

  initial begin
    rrst = 1'b1; fifo_rst = 1'b1; m_ready = 1'b0;

    // Reset held while the FIFO already holds data, then streaming 0x00..0x3F.
    repeat (2) @(posedge rclk);
    #1;
    fifo_rst = 1'b0;
    for (int i = 0; i < 64; i++) write_word(8'(i));
    repeat (4) @(posedge rclk);
    @(negedge rclk);
    check("hold_rinc", rinc16, 0);
    check("hold_valid", v16, 0);
    @(posedge rclk);
    #1;
    m_ready = 1'b1; rrst = 1'b0;
    @(negedge rclk);
    check("rel_rinc_c0", rinc16, 1);
    check("rel_valid_c0", v16, 0);
    @(negedge rclk);
    check("rel_valid_c1", v16, 0);
    @(negedge rclk);
    check("rel_valid_c2", v16, 1);
    check("rel_data_c2", d16, 8'h00);
    for (int k = 0; k < 200 && n_fire < 64; k++) @(posedge rclk);
    check("stream_beats", n_fire, 64);
    check("stream_span", last_cyc - first_cyc, 63);
    check("stream_nlast", lq16.size(), 4);
    for (int i = 0; i < 4; i++) check("stream_last_idx", (lq16.size() > i) ? lq16[i] : -1, 16 * i + 15);
    $display("stream: %0d beats, %0d last markers", dut_fires, lq16.size());

    // Backpressure: exactly two pops while stalled, then random ready drains all ten.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_word(8'(i));
    repeat (12) @(posedge rclk);
    #1;
    check("bp_pops_stalled", dut_pops, 2);
    check("bp_data_hold", d16, 8'h00);
    check("bp_valid", v16, 1);
    random_until(10, 400, "bp_all_beats");
    m_ready = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    check("bp_dut_fires", dut_fires, 10);
    check("bp_dut_pops", dut_pops, 10);
    $display("backpressure: %0d pops, %0d beats", dut_pops, dut_fires);

    // Empty boundary: two words 20 cycles apart; m_valid must drop in between.
    do_reset();
    m_ready = 1'b1;
    write_word(8'h5A);
    repeat (20) @(posedge rclk);
    #1;
    write_word(8'hA5);
    repeat (10) @(posedge rclk);
    #1;
    check("empty_beats", dut_fires, 2);
    check("empty_vrise", vrise, 2);
    $display("empty boundary: %0d beats, %0d valid bursts", dut_fires, vrise);

    // Framing for PKT_LEN 1 and 3 over seven beats.
    do_reset();
    for (int i = 0; i < 7; i++) write_word(8'($urandom));
    random_until(7, 300, "pkt_beats");
    check("pkt1_nlast", lq1_cnt, 7);
    check("pkt3_nlast", lq3.size(), 2);
    check("pkt3_first", (lq3.size() > 0) ? lq3[0] : -1, 2);
    check("pkt3_second", (lq3.size() > 1) ? lq3[1] : -1, 5);
    $display("framing: pkt1 %0d lasts, pkt3 %0d lasts", lq1_cnt, lq3.size());

    // Reset asserted mid-stream with a full buffer; outputs clear without a clock edge.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_word(8'(8'h40 + i));
    repeat (8) @(posedge rclk);
    #1;
    check("mr_pops_before", dut_pops, 2);
    @(posedge rclk);
    #3;
    rrst = 1'b1; fifo_rst = 1'b1; wr_cnt = 0;
    #1;
    check("mr_async_valid", v16, 0);
    check("mr_async_rinc", rinc16, 0);
    check("mr_async_data", d16, 0);
    check("mr_async_last", last16, 0);
    repeat (2) @(posedge rclk);
    #1;
    fifo_rst = 1'b0; rrst = 1'b0;
    for (int i = 0; i < 20; i++) write_word(8'($urandom));
    random_until(20, 500, "mr_restart_beats");
    check("mr_nlast", lq16.size(), 1);
    check("mr_first_last", (lq16.size() > 0) ? lq16[0] : -1, 15);
    $display("mid-stream reset: %0d beats after restart", dut_fires);

    // Random soak: sporadic writes and ready, then drain.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      @(posedge rclk);
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) write_word(8'($urandom));
    end
    m_ready = 1'b1;
    for (int k = 0; k < 100 && n_fire < wr_cnt; k++) @(posedge rclk);
    #1;
    check("soak_beats", n_fire, wr_cnt);
    check("soak_dut_fires", dut_fires, wr_cnt);
    $display("soak: %0d words written, %0d beats", wr_cnt, dut_fires);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
